// File: rtl/timer_counter.sv
// Bus-mapped down-counter with one-shot and auto-reload modes.
// Raises an interrupt flag when the count reaches zero.
module timer_counter (
    input  logic        clk,
    input  logic        reset,
    input  logic [29:0] Addr,
    input  logic        WE,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        IRQ
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LOAD = 2'b01,
        CNT  = 2'b10,
        INT  = 2'b11
    } state_t;

    state_t      state_reg;
    logic [3:0]  ctrl_reg;
    logic [31:0] preset_reg;
    logic [31:0] count_reg;
    logic        flag_reg;

    logic        en;
    logic        auto_reload;
    logic [1:0]  reg_sel;
    logic        ctrl_wr;
    logic        preset_wr;
    logic        unused_addr;

    // Addr carries byte-address bits [31:2]; its two LSBs are byte-address bits [3:2].
    assign reg_sel     = Addr[1:0];
    assign unused_addr = ^Addr[29:2];

    assign en          = ctrl_reg[0];
    assign auto_reload = (ctrl_reg[2:1] == 2'b01);
    assign ctrl_wr     = WE && (reg_sel == 2'b00);
    assign preset_wr   = WE && (reg_sel == 2'b01);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg  <= IDLE;
            ctrl_reg   <= 4'h0;
            preset_reg <= 32'h0;
            count_reg  <= 32'h0;
            flag_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (en)
                        state_reg <= LOAD;
                end
                LOAD: begin
                    // A disable arriving here abandons the reload so COUNT keeps its value.
                    if (!en) begin
                        state_reg <= IDLE;
                    end else begin
                        count_reg <= preset_reg;
                        state_reg <= CNT;
                    end
                end
                CNT: begin
                    if (!en) begin
                        state_reg <= IDLE;
                    end else if (count_reg > 32'd1) begin
                        count_reg <= count_reg - 32'd1;
                    end else begin
                        count_reg <= 32'h0;
                        flag_reg  <= 1'b1;
                        state_reg <= INT;
                    end
                end
                INT: begin
                    if (auto_reload) begin
                        // Reload straight away so the pulse period is max(PRESET,1)+2 cycles.
                        flag_reg  <= 1'b0;
                        state_reg <= en ? LOAD : IDLE;
                    end else begin
                        ctrl_reg[0] <= 1'b0;
                        state_reg   <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase

            if (preset_wr)
                preset_reg <= Din;

            // Placed after the FSM so a bus write overrides the hardware EN clear.
            if (ctrl_wr) begin
                ctrl_reg <= Din[3:0];
                if (!auto_reload)
                    flag_reg <= 1'b0;
            end
        end
    end

    always_comb begin
        Dout = 32'h0;
        case (reg_sel)
            2'b00:   Dout = {28'h0, ctrl_reg};
            2'b01:   Dout = preset_reg;
            2'b10:   Dout = count_reg;
            default: Dout = 32'h0;
        endcase
    end

    assign IRQ = ctrl_reg[3] & flag_reg;

endmodule

// File: tb/tb_timer_counter.sv
// Self-checking bench for timer_counter: directed scenarios plus randomized
// PRESET/CTRL trials checked against closed-form timing predictions.
module tb_timer_counter;

    logic        clk = 1'b0;
    logic        reset;
    logic [29:0] Addr;
    logic        WE;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic        IRQ;

    int n_vec = 0;
    int n_err = 0;

    timer_counter dut (
        .clk   (clk),
        .reset (reset),
        .Addr  (Addr),
        .WE    (WE),
        .Din   (Din),
        .Dout  (Dout),
        .IRQ   (IRQ)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input int a, input logic [31:0] d);
        Addr = 30'(a);
        Din  = d;
        WE   = 1'b1;
        tick();
        WE   = 1'b0;
    endtask

    task automatic read_check(input int a, input logic [31:0] exp, input string tag);
        Addr = 30'(a);
        #1;
        n_vec++;
        assert (Dout === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, Dout, exp);
        end
    endtask

    task automatic irq_check(input logic exp, input string tag);
        n_vec++;
        assert (IRQ === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, IRQ, exp);
        end
    endtask

    task automatic reset_dut();
        reset = 1'b0;
        #1;
        reset = 1'b1;
    endtask

    // Predicts COUNT/IRQ/CTRL after edges n_first..n_last following the
    // enabling CTRL write, from the latency rules: LOAD one edge after the
    // write, COUNT=PRESET one edge later, terminal count max(P,1) edges after
    // that, auto-reload period max(P,1)+2.  Assumes COUNT=0 and FLAG=0 at start.
    task automatic check_run(input int p, input logic [31:0] ctrl,
                             input int n_first, input int n_last);
        int          pp;
        int          m;
        bit          autor;
        bit          flag;
        logic [31:0] ec;
        logic [31:0] ectrl;
        pp    = (p < 1) ? 1 : p;
        autor = (ctrl[2:1] == 2'b01);
        for (int n = n_first; n <= n_last; n++) begin
            tick();
            m = autor ? (n - 1) % (pp + 2) : n - 1;
            if (m == 0)
                ec = 32'h0;
            else if (m == 1)
                ec = 32'(p);
            else if (m <= pp)
                ec = 32'(p - m + 1);
            else
                ec = 32'h0;
            flag  = autor ? (m == pp + 1) : (m >= pp + 1);
            ectrl = (!autor && m >= pp + 2) ? (ctrl & 32'hE) : (ctrl & 32'hF);
            irq_check(ctrl[3] & flag, $sformatf("irq p=%0d n=%0d", p, n));
            read_check(2, ec, $sformatf("count p=%0d n=%0d", p, n));
            read_check(0, ectrl, $sformatf("ctrl p=%0d n=%0d", p, n));
        end
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] rc;
        int          p;
        int          pp;
        int          ncyc;

        reset = 1'b0;
        WE    = 1'b0;
        Addr  = 30'h0;
        Din   = 32'h0;

        // Reset state, observed while reset is held low
        repeat (2) @(posedge clk);
        #1;
        for (int a = 0; a < 4; a++)
            read_check(a, 32'h0, $sformatf("reset_reg%0d", a));
        irq_check(1'b0, "reset_irq");
        reset = 1'b1;

        // One-shot, PRESET=5, CTRL=0x9: IRQ at edge 7, sticky, CTRL reads 0x8
        tick();
        write_reg(1, 32'd5);
        write_reg(0, 32'h9);
        check_run(5, 32'h9, 1, 12);
        write_reg(0, 32'h0);
        irq_check(1'b0, "oneshot_irq_clear");
        read_check(0, 32'h0, "oneshot_ctrl_clear");

        // Auto-reload, PRESET=5, CTRL=0xB: pulse every 7 cycles
        reset_dut();
        write_reg(1, 32'd5);
        write_reg(0, 32'hB);
        check_run(5, 32'hB, 1, 22);

        // Masked interrupt, PRESET=3, CTRL=0x1, then CTRL=0x8
        reset_dut();
        write_reg(1, 32'd3);
        write_reg(0, 32'h1);
        check_run(3, 32'h1, 1, 8);
        write_reg(0, 32'h8);
        irq_check(1'b0, "masked_flag_cleared");
        read_check(0, 32'h8, "masked_ctrl");

        // PRESET=0 boundary: IRQ 3 edges after the write
        reset_dut();
        write_reg(1, 32'd0);
        write_reg(0, 32'h9);
        check_run(0, 32'h9, 1, 6);

        // PRESET write mid-count, disable mid-count, ignored writes
        reset_dut();
        write_reg(1, 32'd9);
        write_reg(0, 32'h3);
        check_run(9, 32'h3, 1, 3);
        write_reg(1, 32'd2);
        read_check(2, 32'd7, "count_after_preset_write");
        check_run(9, 32'h3, 5, 7);
        write_reg(0, 32'h0);
        read_check(2, 32'd3, "count_at_disable");
        for (int k = 0; k < 4; k++) begin
            tick();
            read_check(2, 32'd3, $sformatf("count_hold%0d", k));
            irq_check(1'b0, $sformatf("irq_hold%0d", k));
        end
        write_reg(2, 32'hFFFF_FFFF);
        read_check(2, 32'd3, "count_write_ignored");
        write_reg(3, 32'hFFFF_FFFF);
        read_check(3, 32'h0, "reserved_read");
        read_check(1, 32'd2, "preset_read");

        // Reset mid-count in auto-reload with COUNT=3
        reset_dut();
        write_reg(1, 32'd5);
        write_reg(0, 32'hB);
        check_run(5, 32'hB, 1, 4);
        reset = 1'b0;
        for (int a = 0; a < 4; a++)
            read_check(a, 32'h0, $sformatf("midreset_reg%0d", a));
        irq_check(1'b0, "midreset_irq");
        reset = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            read_check(2, 32'h0, $sformatf("postreset_count%0d", k));
            irq_check(1'b0, $sformatf("postreset_irq%0d", k));
        end

        // Collision: CTRL=0xB written on the INT-state edge in one-shot mode
        reset_dut();
        write_reg(1, 32'd2);
        write_reg(0, 32'h9);
        check_run(2, 32'h9, 1, 4);
        write_reg(0, 32'hB);
        read_check(0, 32'hB, "collision_ctrl");
        irq_check(1'b0, "collision_flag");
        check_run(2, 32'hB, 1, 8);

        // Randomized trials: random PRESET, mode, mask and junk upper CTRL bits
        for (int t = 0; t < 24; t++) begin
            r  = $urandom;
            rc = {r[31:1], 1'b1};
            p  = int'($urandom_range(0, 12));
            pp = (p < 1) ? 1 : p;
            ncyc = (rc[2:1] == 2'b01) ? 3 * (pp + 2) + 1 : pp + 6;
            reset_dut();
            write_reg(1, 32'(p));
            write_reg(0, rc);
            check_run(p, rc, 1, ncyc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
